// File: rtl/fpu_dispatch.sv
// fpu_dispatch: FIFO-buffered issue stage that hands FP requests to the FPU one at a time
// and returns each result (or a watchdog abort) on a valid/ready response port.
module fpu_dispatch #(
  parameter int BIT_WIDTH = 32,
  parameter int OP_WIDTH  = 5,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [OP_WIDTH-1:0]        req_op,
  input  logic [BIT_WIDTH-1:0]       req_a,
  input  logic [BIT_WIDTH-1:0]       req_b,
  output logic                       fpu_instr_received,
  output logic [OP_WIDTH-1:0]        fpu_op_mask,
  output logic [BIT_WIDTH-1:0]       fpu_input_1,
  output logic [BIT_WIDTH-1:0]       fpu_input_2,
  input  logic                       fpu_unit_busy,
  input  logic [BIT_WIDTH-1:0]       fpu_reg_lo,
  input  logic [BIT_WIDTH-1:0]       fpu_reg_hi,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [BIT_WIDTH-1:0]       rsp_lo,
  output logic [BIT_WIDTH-1:0]       rsp_hi,
  output logic                       rsp_timeout,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESP} state_t;
  state_t               r_state;
  logic [OP_WIDTH-1:0]  r_op_mem [DEPTH];
  logic [BIT_WIDTH-1:0] r_a_mem  [DEPTH];
  logic [BIT_WIDTH-1:0] r_b_mem  [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic [WW-1:0]        r_wd;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_timeout;
  assign w_pop      = r_state == S_IDLE && r_count != '0 && !rsp_valid;
  // a full FIFO still accepts in the cycle its head is popped
  assign req_ready  = r_count != CW'(DEPTH) || w_pop;
  assign w_push     = req_valid && req_ready;
  // watchdog counts cycles since issue; abort on the edge it would reach TIMEOUT-1
  assign w_timeout  = r_wd == WW'(TIMEOUT - 2);
  assign fifo_count = r_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wptr] <= req_op;
      r_a_mem[r_wptr]  <= req_a;
      r_b_mem[r_wptr]  <= req_b;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= S_IDLE;
      r_wd               <= '0;
      fpu_instr_received <= 1'b0;
      fpu_op_mask        <= '0;
      fpu_input_1        <= '0;
      fpu_input_2        <= '0;
      rsp_valid          <= 1'b0;
      rsp_lo             <= '0;
      rsp_hi             <= '0;
      rsp_timeout        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (w_pop) begin
            fpu_op_mask        <= r_op_mem[r_rptr];
            fpu_input_1        <= r_a_mem[r_rptr];
            fpu_input_2        <= r_b_mem[r_rptr];
            fpu_instr_received <= 1'b1;
            r_state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          fpu_instr_received <= 1'b0;
          r_wd               <= r_wd + WW'(1);
          r_state            <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          r_wd <= r_wd + WW'(1);
          if (w_timeout) begin
            rsp_lo      <= '0;
            rsp_hi      <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_state == S_WAIT_DONE && !fpu_unit_busy) begin
            rsp_lo      <= fpu_reg_lo;
            rsp_hi      <= fpu_reg_hi;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_state == S_WAIT_BUSY && fpu_unit_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: randomized bench with a transaction-level scoreboard and a behavioural FPU
// that raises busy after each start pulse and publishes results as busy drops.
module tb_fpu_dispatch;
  localparam int BW = 32;
  localparam int OW = 5;
  localparam int DEPTH = 4;
  localparam int TO = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [OW-1:0] HANG_OP = 5'd31;
  typedef struct {
    logic [OW-1:0] op;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } req_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic [OW-1:0] req_op = '0;
  logic [BW-1:0] req_a = '0;
  logic [BW-1:0] req_b = '0;
  logic fpu_unit_busy = 1'b0;
  logic [BW-1:0] fpu_reg_lo = '0;
  logic [BW-1:0] fpu_reg_hi = '0;
  logic rsp_ready = 1'b0;
  logic req_ready, fpu_instr_received, rsp_valid, rsp_timeout;
  logic [OW-1:0] fpu_op_mask;
  logic [BW-1:0] fpu_input_1, fpu_input_2, rsp_lo, rsp_hi;
  logic [CW-1:0] fifo_count;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses = 0;
  int dmin = 1;
  int dmax = 4;
  bit bp = 1'b0;
  req_t exp_q[$];
  req_t iss_q[$];

  fpu_dispatch #(.BIT_WIDTH(BW), .OP_WIDTH(OW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .fpu_instr_received(fpu_instr_received), .fpu_op_mask(fpu_op_mask),
    .fpu_input_1(fpu_input_1), .fpu_input_2(fpu_input_2), .fpu_unit_busy(fpu_unit_busy),
    .fpu_reg_lo(fpu_reg_lo), .fpu_reg_hi(fpu_reg_hi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_timeout(rsp_timeout), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] fake(input logic [OW-1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
    fake = (a == 32'h4000_0000 && b == 32'h4040_0000) ? 64'h0000_0000_40C0_0000 : {a ^ b, a + b + 32'(op)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = bp ? 1'b0 : ($urandom_range(3, 0) != 0);
  end

  // behavioural FPU: op HANG_OP never raises busy, others stay busy dmin..dmax cycles
  initial begin
    req_t cur;
    int left = 0;
    bit go = 1'b0;
    cur = '{'0, '0, '0};
    forever begin
      @(negedge clk);
      if (rst_n && fpu_instr_received) begin
        cur = '{fpu_op_mask, fpu_input_1, fpu_input_2};
        go = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        go = 1'b0;
        left = 0;
        fpu_unit_busy = 1'b0;
      end else if (go) begin
        go = 1'b0;
        if (cur.op != HANG_OP) begin
          fpu_unit_busy = 1'b1;
          left = $urandom_range(dmax, dmin);
          fpu_reg_lo = $urandom;
          fpu_reg_hi = $urandom;
        end
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          chk("held_op", 64'(fpu_op_mask), 64'(cur.op));
          chk("held_in1", 64'(fpu_input_1), 64'(cur.a));
          chk("held_in2", 64'(fpu_input_2), 64'(cur.b));
          fpu_unit_busy = 1'b0;
          {fpu_reg_hi, fpu_reg_lo} = fake(cur.op, cur.a, cur.b);
        end
      end
    end
  end

  // scoreboard: in-order requests, one op outstanding, issue only when idle and queued
  initial begin
    req_t r;
    int cnt = 0;
    int issue_cyc = 0;
    bit outst = 1'b0;
    bit pop = 1'b0;
    bit pop_prev = 1'b0;
    bit prev_v = 1'b0;
    bit prev_r = 1'b0;
    logic [BW-1:0] prev_lo = '0;
    logic [BW-1:0] prev_hi = '0;
    logic prev_to = 1'b0;
    logic [BW-1:0] elo, ehi;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        iss_q.delete();
        cnt = 0;
        outst = 1'b0;
        pop_prev = 1'b0;
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        chk("pulse", 64'(fpu_instr_received), 64'(pop_prev));
        if (fpu_instr_received) begin
          pulses++;
          cnt--;
          outst = 1'b1;
          issue_cyc = cyc;
          if (iss_q.size() == 0) chk("spurious_issue", 64'(fpu_instr_received), 64'(0));
          else begin
            r = iss_q.pop_front();
            chk("issue_op", 64'(fpu_op_mask), 64'(r.op));
            chk("issue_a", 64'(fpu_input_1), 64'(r.a));
            chk("issue_b", 64'(fpu_input_2), 64'(r.b));
          end
        end
        chk("count", 64'(fifo_count), 64'(cnt));
        pop = !outst && cnt > 0;
        chk("req_ready", 64'(req_ready), 64'(cnt < DEPTH || pop));
        if (req_valid && req_ready) begin
          r = '{req_op, req_a, req_b};
          exp_q.push_back(r);
          iss_q.push_back(r);
          cnt++;
        end
        if (!rsp_valid) chk("timeout_idle", 64'(rsp_timeout), 64'(0));
        if (rsp_valid && !prev_v && exp_q.size() > 0) begin
          if (exp_q[0].op == HANG_OP) chk("timeout_latency", 64'(cyc - issue_cyc), 64'(TO - 1));
          else chk("min_latency", 64'(cyc - issue_cyc >= 3), 64'(1));
        end
        if (rsp_valid && prev_v && !prev_r) begin
          chk("hold_lo", 64'(rsp_lo), 64'(prev_lo));
          chk("hold_hi", 64'(rsp_hi), 64'(prev_hi));
          chk("hold_to", 64'(rsp_timeout), 64'(prev_to));
        end
        if (rsp_valid && rsp_ready) begin
          outst = 1'b0;
          if (exp_q.size() == 0) chk("spurious_rsp", 64'(rsp_valid), 64'(0));
          else begin
            r = exp_q.pop_front();
            if (r.op == HANG_OP) {ehi, elo} = 64'(0);
            else {ehi, elo} = fake(r.op, r.a, r.b);
            chk("rsp_lo", 64'(rsp_lo), 64'(elo));
            chk("rsp_hi", 64'(rsp_hi), 64'(ehi));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(r.op == HANG_OP));
          end
        end
        pop_prev = pop;
        prev_v = rsp_valid;
        prev_r = rsp_ready;
        prev_lo = rsp_lo;
        prev_hi = rsp_hi;
        prev_to = rsp_timeout;
      end
    end
  end

  task automatic push(input logic [OW-1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
    int n = 0;
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) chk("push_wait", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rsp_valid) chk("rsp_wait", 64'(rsp_valid), 64'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
    chk({tag, "_count"}, 64'(fifo_count), 64'(0));
    chk({tag, "_pulse"}, 64'(fpu_instr_received), 64'(0));
    chk({tag, "_op_mask"}, 64'(fpu_op_mask), 64'(0));
    chk({tag, "_in1"}, 64'(fpu_input_1), 64'(0));
    chk({tag, "_rsp_lo"}, 64'(rsp_lo), 64'(0));
    chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int p0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // single FMUL with a 3-cycle busy FPU
    dmin = 3;
    dmax = 3;
    push(5'd2, 32'h4000_0000, 32'h4040_0000);
    wait_rsp();
    chk("fmul_lo", 64'(rsp_lo), 64'h40C0_0000);
    chk("fmul_timeout", 64'(rsp_timeout), 64'(0));
    wait_drain();
    // fill the FIFO behind a held response, then release it with a full push/pop
    bp = 1'b1;
    dmin = 1;
    dmax = 10;
    push(5'd1, $urandom, $urandom);
    wait_rsp();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push(5'($urandom_range(30, 0)), $urandom, $urandom);
    @(negedge clk);
    chk("full_count", 64'(fifo_count), 64'(DEPTH));
    chk("full_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    fork
      push(5'd9, $urandom, $urandom);
    join_none
    p0 = pulses;
    repeat (10) @(negedge clk);
    chk("bp_no_pulse", 64'(pulses - p0), 64'(0));
    chk("bp_valid", 64'(rsp_valid), 64'(1));
    @(posedge clk);
    #1;
    bp = 1'b0;
    n = 0;
    @(negedge clk);
    while (!fpu_instr_received && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("full_pushpop_pulse", 64'(fpu_instr_received), 64'(1));
    chk("full_pushpop_count", 64'(fifo_count), 64'(DEPTH));
    wait_drain();
    // hung FPU op followed by a normal one
    dmin = 1;
    dmax = 5;
    bp = 1'b1;
    push(HANG_OP, $urandom, $urandom);
    push(5'd7, $urandom, $urandom);
    wait_rsp();
    chk("hang_timeout", 64'(rsp_timeout), 64'(1));
    chk("hang_lo", 64'(rsp_lo), 64'(0));
    chk("hang_hi", 64'(rsp_hi), 64'(0));
    @(posedge clk);
    #1;
    bp = 1'b0;
    wait_drain();
    // random traffic
    dmin = 1;
    dmax = 8;
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(3, 0);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
      push(($urandom_range(15, 0) == 0) ? HANG_OP : 5'($urandom_range(30, 0)), $urandom, $urandom);
    end
    wait_drain();
    // reset while the FPU is mid-operation
    dmin = 12;
    dmax = 12;
    push(5'd3, $urandom, $urandom);
    push(5'd4, $urandom, $urandom);
    push(5'd5, $urandom, $urandom);
    n = 0;
    @(negedge clk);
    while (!fpu_unit_busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("pre_reset_busy", 64'(fpu_unit_busy), 64'(1));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outputs("midop_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_valid", 64'(rsp_valid), 64'(0));
    chk("post_reset_count", 64'(fifo_count), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
